// File: rtl/rip_mem_pkg.sv
// Shared definitions for the RV32I data-memory access unit: funct3 codes,
// FSM state type and the alignment helpers used by the access unit.
package rip_mem_pkg;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    STORE_MERGE,
    RESP
  } state_t;

  // Legal funct3 codes differ between loads and stores.
  function automatic logic funct3_valid(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // An illegal funct3 counts as misaligned, as does any halfword or word
  // access whose address is not a multiple of its size.
  function automatic logic is_misaligned(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lo);
    logic bad;
    bad = !funct3_valid(we, f3);
    case (f3[1:0])
      2'b01:   if (lo[0])       bad = 1'b1;
      2'b10:   if (lo != 2'b00) bad = 1'b1;
      default: ;
    endcase
    return bad;
  endfunction

  // Byte lane of an access after clearing the offset bits below its size.
  function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] lane;
    case (f3[1:0])
      2'b00:   lane = lo;
      2'b01:   lane = {lo[1], 1'b0};
      default: lane = 2'b00;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/rip_mem_access_unit_if.sv
// Request/response bus between a core and the memory access unit.
// master = requester (core side), slave = the access unit.
interface rip_mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rip_load_extract.sv
// Combinational load-data extraction: picks the addressed byte/halfword out
// of a 32-bit BRAM word and sign- or zero-extends it according to funct3.
module rip_load_extract
  import rip_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = word[gi*8 +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[lane];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  // Width select and extension
  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/rip_mem_access_unit.sv
// RV32I load/store unit in front of port 1 of a 32-bit data BRAM.
// Loads take one BRAM read, SW a single write, SB/SH a read-modify-write.
// Optional feature macro: RIP_MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// or illegal-funct3 requests skip the BRAM and answer with rsp_err; when not
// defined, they are forced aligned (illegal codes act as LW/SW).
module rip_mem_access_unit
  import rip_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  rip_mem_access_unit_if.slave  bus,
  output logic                  bram_enable,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_din,
  input  logic [31:0]           bram_dout
);

  state_t                state_reg,  state_next;
  logic [2:0]            funct3_reg, funct3_next;
  logic [1:0]            lane_reg,   lane_next;
  logic [ADDR_WIDTH-1:0] waddr_reg,  waddr_next;
  logic [15:0]           wdata_reg,  wdata_next;
  logic                  err_reg,    err_next;
  logic [31:0]           rdata_reg,  rdata_next;

  logic [ADDR_WIDTH-1:0] req_word;
  logic [2:0]            eff_funct3;
  logic [1:0]            eff_lane;
  logic [31:0]           load_data;
  logic [3:0]            merge_be;
  logic [31:0]           wdata_rep;
  logic [31:0]           merged_word;
  logic                  unused_addr_hi;

  assign req_word       = bus.req_addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH+2];

  // Illegal codes collapse to word width (LW and SW share the same code).
  assign eff_funct3 = funct3_valid(bus.req_we, bus.req_funct3) ? bus.req_funct3 : F3_LW;
  assign eff_lane   = align_lane(eff_funct3, bus.req_addr[1:0]);

  rip_load_extract u_load_extract (
    .word   (bram_dout),
    .funct3 (funct3_reg),
    .lane   (lane_reg),
    .data   (load_data)
  );

  // Byte enables and replicated store data for the SB/SH merge
  always_comb begin
    merge_be  = (funct3_reg[1:0] == 2'b00) ? (4'b0001 << lane_reg)
                                           : (lane_reg[1] ? 4'b1100 : 4'b0011);
    wdata_rep = funct3_reg[0] ? {2{wdata_reg}} : {4{wdata_reg[7:0]}};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[gi*8 +: 8] = merge_be[gi] ? wdata_rep[gi*8 +: 8]
                                                   : bram_dout[gi*8 +: 8];
    end
  endgenerate

  // Next-state logic and all outputs; reset forces every output quiet
  always_comb begin
    state_next  = state_reg;
    funct3_next = funct3_reg;
    lane_next   = lane_reg;
    waddr_next  = waddr_reg;
    wdata_next  = wdata_reg;
    err_next    = err_reg;
    rdata_next  = rdata_reg;

    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'd0;
    bus.rsp_err   = 1'b0;
    bram_enable   = 1'b0;
    bram_we       = 1'b0;
    bram_addr     = waddr_reg;
    bram_din      = 32'd0;

    if (rst) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          bus.req_ready = 1'b1;
          bram_addr     = req_word;
          if (bus.req_valid) begin
            funct3_next = eff_funct3;
            lane_next   = eff_lane;
            waddr_next  = req_word;
            wdata_next  = bus.req_wdata[15:0];
            rdata_next  = 32'd0;
            err_next    = 1'b0;
`ifdef RIP_MEM_MISALIGN_TRAP_EN
            if (is_misaligned(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
              err_next   = 1'b1;
              state_next = RESP;
            end else
`endif
            if (!bus.req_we) begin
              bram_enable = 1'b1;
              state_next  = LOAD_WAIT;
            end else if (eff_funct3 == F3_SW) begin
              bram_enable = 1'b1;
              bram_we     = 1'b1;
              bram_din    = bus.req_wdata;
              state_next  = RESP;
            end else begin
              // Sub-word store: fetch the word so the untouched lanes survive
              bram_enable = 1'b1;
              state_next  = STORE_MERGE;
            end
          end
        end
        LOAD_WAIT: begin
          rdata_next = load_data;
          state_next = RESP;
        end
        STORE_MERGE: begin
          bram_enable = 1'b1;
          bram_we     = 1'b1;
          bram_din    = merged_word;
          state_next  = RESP;
        end
        RESP: begin
          bus.rsp_valid = 1'b1;
          bus.rsp_rdata = rdata_reg;
          bus.rsp_err   = err_reg;
          state_next    = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and request-field registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      funct3_reg <= F3_LW;
      lane_reg   <= 2'b00;
      waddr_reg  <= '0;
      wdata_reg  <= 16'd0;
      err_reg    <= 1'b0;
      rdata_reg  <= 32'd0;
    end else begin
      state_reg  <= state_next;
      funct3_reg <= funct3_next;
      lane_reg   <= lane_next;
      waddr_reg  <= waddr_next;
      wdata_reg  <= wdata_next;
      err_reg    <= err_next;
      rdata_reg  <= rdata_next;
    end
  end

endmodule

// File: tb/tb_rip_mem_access_unit.sv
// Self-checking bench for rip_mem_access_unit: directed cases plus random
// loads/stores compared with a byte-level memory model.
module tb_rip_mem_access_unit;

  localparam int AW = 10;
  localparam int NWORDS = 1 << AW;
`ifdef RIP_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rip_mem_access_unit_if bus ();

  logic          bram_enable, bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din, bram_dout;

  rip_mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .bram_enable (bram_enable),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .bram_dout   (bram_dout)
  );

  // BRAM port with registered read, plus a preload port for the bench
  logic [31:0]   mem [NWORDS];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bram_enable) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout      <= mem[bram_addr];
    end
  end

  logic [31:0] ref_mem [NWORDS];
  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          lat;
    int          en;
    int          we;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] new_word;
    int          idx;
  } exp_t;

  // Reference behaviour from the access rules, using shifts and masks.
  function automatic exp_t predict(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int size, off;
    bit valid, mis;
    logic [31:0] w, sh, mask;
    e.idx = int'(a[AW+1:2]);
    w = ref_mem[e.idx];
    valid = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = valid ? int'(f3[1:0]) : 2;
    mis = !valid || (size == 1 && a[0]) || (size == 2 && a[1:0] != 2'b00);
    e.new_word = w;
    e.err = 1'b0;
    e.rdata = 32'd0;
    if (TRAP && mis) begin
      e.lat = 1; e.en = 0; e.we = 0; e.err = 1'b1;
      return e;
    end
    off = (size == 0) ? int'(a[1:0]) : (size == 1) ? (a[1] ? 2 : 0) : 0;
    if (!we) begin
      e.lat = 2; e.en = 1; e.we = 0;
      sh = w >> (8 * off);
      if (size == 0) begin
        e.rdata = sh & 32'hFF;
        if (!f3[2] && valid && sh[7]) e.rdata = e.rdata | 32'hFFFF_FF00;
      end else if (size == 1) begin
        e.rdata = sh & 32'hFFFF;
        if (!f3[2] && valid && sh[15]) e.rdata = e.rdata | 32'hFFFF_0000;
      end else begin
        e.rdata = w;
      end
    end else if (size == 2) begin
      e.lat = 1; e.en = 1; e.we = 1;
      e.new_word = wd;
    end else begin
      e.lat = 2; e.en = 2; e.we = 1;
      mask = ((size == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
      e.new_word = (w & ~mask) | ((wd << (8 * off)) & mask);
    end
    return e;
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = AW'(idx);
    pre_data = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One complete request from an idle unit, checked against the model.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] got_rdata);
    exp_t e;
    int en_cnt, we_cnt, lat;
    bit done;
    logic got_err;
    e = predict(we, f3, a, wd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    #1;
    check("req_ready_idle", bus.req_ready, 1);
    en_cnt = 0; we_cnt = 0; lat = -1; done = 0;
    got_rdata = 32'd0; got_err = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
      end
      en_cnt += int'(bram_enable);
      we_cnt += int'(bram_we);
      if (bus.rsp_valid) begin
        done = 1; lat = c;
        got_rdata = bus.rsp_rdata;
        got_err = bus.rsp_err;
      end
    end
    bus.req_valid = 1'b0;
    check("rsp_seen", done, 1);
    check("latency", lat, e.lat);
    check("bram_en_cycles", en_cnt, e.en);
    check("bram_we_cycles", we_cnt, e.we);
    check("rsp_rdata", got_rdata, e.rdata);
    check("rsp_err", got_err, e.err);
    check("mem_word", mem[e.idx], e.new_word);
    ref_mem[e.idx] = e.new_word;
    n_txn++;
    $display("txn %0d: %s f3=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
             n_txn, we ? "ST" : "LD", f3, a, wd, got_rdata, got_err, lat);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] lw_a [3];
    logic [2:0]  lw_f [3];
    int acc_cyc [$];
    exp_t q [$];
    exp_t e;
    int k, n_rsp;

    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0000_0020;
    bus.req_wdata = 32'h1111_2222;

    // Reset state, with a request pending to show it is ignored
    @(negedge clk); #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_bram_enable", bram_enable, 0);
    check("rst_bram_we", bram_we, 0);
    bus.req_valid = 1'b0;

    for (int i = 0; i < NWORDS; i++) preload(i, $urandom);
    preload(5, 32'h8899_AABB);
    @(negedge clk);
    rst = 1'b0;

    // Directed accesses on word 5 and word 8
    run_txn(1'b0, 3'b000, 32'h15, 32'h0, r);
    check("lb_0x15", r, 32'hFFFF_FFAA);
    run_txn(1'b0, 3'b101, 32'h16, 32'h0, r);
    check("lhu_0x16", r, 32'h0000_8899);
    run_txn(1'b0, 3'b010, 32'h14, 32'h0, r);
    check("lw_0x14", r, 32'h8899_AABB);
    run_txn(1'b1, 3'b000, 32'h17, 32'h12, r);
    check("sb_0x17_word5", mem[5], 32'h1299_AABB);
    run_txn(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, r);
    check("sw_0x20_word8", mem[8], 32'hDEAD_BEEF);
    run_txn(1'b0, 3'b010, 32'h22, 32'h0, r);

    // Reset during the merge cycle of SH 0x10 must drop the write
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h10;
    bus.req_wdata = 32'h0000_CAFE;
    #1;
    check("sh_rst_accept", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("sh_rst_bram_we", bram_we, 0);
    check("sh_rst_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", bus.req_ready, 1);
    check("post_rst_rsp_valid", bus.rsp_valid, 0);
    check("sh_rst_word4", mem[4], ref_mem[4]);
    @(negedge clk); #1;
    check("post_rst_rsp_valid2", bus.rsp_valid, 0);

    // Three loads with req_valid held high throughout
    lw_a[0] = 32'h14; lw_f[0] = 3'b010;
    lw_a[1] = 32'h15; lw_f[1] = 3'b100;
    lw_a[2] = 32'h22; lw_f[2] = 3'b001;
    k = 0; n_rsp = 0;
    for (int c = 0; c < 20 && n_rsp < 3; c++) begin
      @(negedge clk);
      if (k < 3) begin
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_funct3 = lw_f[k];
        bus.req_addr = lw_a[k];
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      if (bus.rsp_valid) begin
        e = q.pop_front();
        check("b2b_rdata", bus.rsp_rdata, e.rdata);
        check("b2b_err", bus.rsp_err, e.err);
        n_rsp++;
        $display("txn b2b rsp %0d: rdata=%08h", n_rsp, bus.rsp_rdata);
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc.push_back(c);
        q.push_back(predict(1'b0, lw_f[k], lw_a[k], 32'h0));
        k++;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_rsp_count", n_rsp, 3);
    if (acc_cyc.size() == 3) begin
      check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 3);
      check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 3);
    end else begin
      check("b2b_accept_count", acc_cyc.size(), 3);
    end

    // Randomized mix including misaligned and illegal funct3 codes
    for (int i = 0; i < 80; i++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
